regfile_alu_pipe: RTL

//  Parametrised, pipelined successor to the register-file + ALU datapath: reads two operands, executes an ALU op,

---
 rtl/regfile_alu_pipe_pkg.sv | 24 ++
 rtl/regfile_alu_pipe_if.sv | 35 +++
 rtl/regfile_alu_pipe_alu_core.sv | 48 ++++
 rtl/regfile_alu_pipe.sv | 123 ++++++++++++
 4 files changed

// File: rtl/regfile_alu_pipe_pkg.sv
// Shared opcode encoding and flag bit positions for the register-file/ALU pipeline.
package regfile_alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } alu_op_e;

    localparam int FLAGS_W = 3;
    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 2;

    function automatic logic is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/regfile_alu_pipe_if.sv
// Op request, external register write and result handshake between sequencer and pipeline.
interface regfile_alu_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    import regfile_alu_pipe_pkg::*;

    logic                IN_VALID;
    logic                IN_READY;
    alu_op_e             IN_OP;
    logic [ADDR_W-1:0]   IN_RS1;
    logic [ADDR_W-1:0]   IN_RS2;
    logic [ADDR_W-1:0]   IN_RD;
    logic                EXT_WE;
    logic [ADDR_W-1:0]   EXT_WA;
    logic [DATA_W-1:0]   EXT_WD;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [DATA_W-1:0]   OUT_RESULT;
    logic [ADDR_W-1:0]   OUT_RD;
    logic [FLAGS_W-1:0]  OUT_FLAGS;

    modport master (
        output IN_VALID, IN_OP, IN_RS1, IN_RS2, IN_RD,
        output EXT_WE, EXT_WA, EXT_WD, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_FLAGS
    );

    modport slave (
        input  IN_VALID, IN_OP, IN_RS1, IN_RS2, IN_RD,
        input  EXT_WE, EXT_WA, EXT_WD, OUT_READY,
        output IN_READY, OUT_VALID, OUT_RESULT, OUT_RD, OUT_FLAGS
    );

endinterface

// File: rtl/regfile_alu_pipe_alu_core.sv
// Combinational ALU: result plus {V,C,Z}; SUB is computed as A + ~B + 1 so C means "no borrow".
module alu_core
    import regfile_alu_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]  i_a,
    input  logic [DATA_W-1:0]  i_b,
    input  alu_op_e            i_op,
    output logic [DATA_W-1:0]  o_result,
    output logic [FLAGS_W-1:0] o_flags
);
    localparam int SH_W = $clog2(DATA_W);

    logic              w_sub;
    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W:0]   w_sum;
    logic              w_lt;

    assign w_sub   = (i_op == OP_SUB);
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, w_sub};
    assign w_lt    = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD, OP_SUB: o_result = w_sum[DATA_W-1:0];
            OP_AND:         o_result = i_a & i_b;
            OP_OR:          o_result = i_a | i_b;
            OP_XOR:         o_result = i_a ^ i_b;
            OP_SLT:         o_result = {{(DATA_W-1){1'b0}}, w_lt};
            OP_SLL:         o_result = i_a << i_b[SH_W-1:0];
            OP_SRL:         o_result = i_a >> i_b[SH_W-1:0];
            default:        o_result = '0;
        endcase

        o_flags         = '0;
        o_flags[FLAG_Z] = (o_result == '0);
        if (is_arith(i_op)) begin
            o_flags[FLAG_C] = w_sum[DATA_W];
            // Overflow: both addends share a sign that the sum does not.
            o_flags[FLAG_V] = (i_a[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                              (w_sum[DATA_W-1] != i_a[DATA_W-1]);
        end
    end

endmodule

// File: rtl/regfile_alu_pipe.sv
// Register file + ALU: operand read at issue, EX register, OUT register; result valid two cycles after accept.
// Output backpressure stalls EX; an op reading the destination of the EX op waits until EX advances.
module regfile_alu_pipe
    import regfile_alu_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    regfile_alu_pipe_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]  r_regs [NUM_REGS];

    logic               r_ex_valid;
    alu_op_e            r_ex_op;
    logic [DATA_W-1:0]  r_ex_a;
    logic [DATA_W-1:0]  r_ex_b;
    logic [ADDR_W-1:0]  r_ex_rd;

    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_result;
    logic [ADDR_W-1:0]  r_out_rd;
    logic [FLAGS_W-1:0] r_out_flags;

    logic               w_out_adv;
    logic               w_hazard;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_wb;
    logic [DATA_W-1:0]  w_rs1_val;
    logic [DATA_W-1:0]  w_rs2_val;
    logic [DATA_W-1:0]  w_alu_res;
    logic [FLAGS_W-1:0] w_alu_flags;

    function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Newest value wins: result waiting in OUT, then a same-cycle external write, then the array.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
        if (f_is_zero(a))
            return '0;
        else if (r_out_valid && (r_out_rd == a))
            return r_out_result;
        else if (bus.EXT_WE && (bus.EXT_WA == a))
            return bus.EXT_WD;
        else
            return r_regs[a];
    endfunction

    assign w_out_adv = !r_out_valid || bus.OUT_READY;
    assign w_hazard  = bus.IN_VALID && r_ex_valid &&
                       (((bus.IN_RS1 == r_ex_rd) && !f_is_zero(bus.IN_RS1)) ||
                        ((bus.IN_RS2 == r_ex_rd) && !f_is_zero(bus.IN_RS2)));
    assign w_in_ready = !RST && (!r_ex_valid || w_out_adv) && !w_hazard;
    assign w_accept   = bus.IN_VALID && w_in_ready;
    assign w_wb       = r_out_valid && bus.OUT_READY && !f_is_zero(r_out_rd);
    assign w_rs1_val  = f_read(bus.IN_RS1);
    assign w_rs2_val  = f_read(bus.IN_RS2);

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .i_a      (r_ex_a),
        .i_b      (r_ex_b),
        .i_op     (r_ex_op),
        .o_result (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    // Writeback is assigned last so it overrides an external write to the same register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (bus.EXT_WE && !f_is_zero(bus.EXT_WA)) r_regs[bus.EXT_WA] <= bus.EXT_WD;
            if (w_wb) r_regs[r_out_rd] <= r_out_result;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= OP_ADD;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_rd    <= '0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_op    <= bus.IN_OP;
            r_ex_a     <= w_rs1_val;
            r_ex_b     <= w_rs2_val;
            r_ex_rd    <= bus.IN_RD;
        end else if (w_out_adv) begin
            r_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_rd     <= '0;
            r_out_flags  <= '0;
        end else if (w_out_adv) begin
            r_out_valid <= r_ex_valid;
            if (r_ex_valid) begin
                r_out_result <= w_alu_res;
                r_out_rd     <= r_ex_rd;
                r_out_flags  <= w_alu_flags;
            end
        end
    end

    assign bus.IN_READY   = w_in_ready;
    assign bus.OUT_VALID  = r_out_valid;
    assign bus.OUT_RESULT = r_out_result;
    assign bus.OUT_RD     = r_out_rd;
    assign bus.OUT_FLAGS  = r_out_flags;

endmodule
